// File: rtl/adder_rr_arbiter.sv
// ---------------------------------------------------------------------------
// adder_rr_arbiter
//
// Shares one W-bit adder (a + b + cin) among NREQ requesters. A round-robin
// arbiter picks at most one requester per cycle. The winning operation's
// sum, carry-out and signed overflow are registered, along with the
// winner's ID, into a single-entry output stage that honours backpressure.
//
// Handshake semantics (both sides): a transfer happens on a rising clock
// edge where valid and ready are both 1. Ready may depend combinationally
// on valid. A producer may drop valid before ready is seen, which withdraws
// its request. While valid=1 and ready=0 it must hold its payload stable.
// The result side never drops res_valid or changes res_* without a
// transfer or a reset.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NREQ]     requester i has an operation pending
//   req_ready  out  [NREQ]     requester i granted and accepted this cycle
//   req_a      in   [NREQ*W]   operand A, requester i at [i*W +: W]
//   req_b      in   [NREQ*W]   operand B, same packing
//   req_cin    in   [NREQ]     carry-in per requester
//   res_valid  out             result register holds a valid result
//   res_ready  in              consumer takes the result this cycle
//   res_sum    out  [W]        registered sum
//   res_cout   out             registered carry-out
//   res_of     out             registered signed overflow
//   res_id     out  [IDW]      requester that produced the result
// ---------------------------------------------------------------------------
module adder_rr_arbiter #(
   parameter int W    = 32,
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   input  logic [NREQ-1:0]   req_cin,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [W-1:0]      res_sum,
   output logic              res_cout,
   output logic              res_of,
   output logic [IDW-1:0]    res_id
);

   logic [IDW-1:0] rr_ptr;
   logic           load;
   logic           gnt_found;
   logic [IDW-1:0] gnt_idx;
   logic           accept;
   logic [W-1:0]   a_sel;
   logic [W-1:0]   b_sel;
   logic           cin_sel;
   logic [W:0]     sum_full;
   logic           of_calc;
   logic [IDW-1:0] ptr_next;

   // The output stage can take a new result when empty or being drained.
   assign load = ~res_valid | res_ready;

   // Round-robin scan: first valid requester starting at rr_ptr, wrapping
   // modulo NREQ. The sum is kept one bit wider so the wrap works for any
   // NREQ, not just powers of two.
   always_comb begin
      logic [IDW:0]   idx_w;
      logic [IDW-1:0] scan;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      idx_w     = '0;
      scan      = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx_w = {1'b0, rr_ptr} + (IDW+1)'(k);
         if (idx_w >= (IDW+1)'(NREQ)) begin
            idx_w = idx_w - (IDW+1)'(NREQ);
         end
         scan = idx_w[IDW-1:0];
         if (!gnt_found && req_valid[scan]) begin
            gnt_found = 1'b1;
            gnt_idx   = scan;
         end
      end
   end

   // One-hot ready; held low for the whole reset period so no handshake
   // can complete while rst_n is asserted.
   always_comb begin
      req_ready = '0;
      if (gnt_found && load && rst_n) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   assign accept = |(req_valid & req_ready);

   // Operand mux for the granted requester.
   always_comb begin
      a_sel   = '0;
      b_sel   = '0;
      cin_sel = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_idx == IDW'(i)) begin
            a_sel   = req_a[i*W +: W];
            b_sel   = req_b[i*W +: W];
            cin_sel = req_cin[i];
         end
      end
   end

   // Shared adder at W+1 bits so the top bit is the carry-out.
   assign sum_full = {1'b0, a_sel} + {1'b0, b_sel} + {{W{1'b0}}, cin_sel};

   // Signed overflow: operands agree in sign but the sum does not.
   assign of_calc = (a_sel[W-1] == b_sel[W-1]) & (sum_full[W-1] != a_sel[W-1]);

   assign ptr_next = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;

   // Result stage and arbiter pointer. rr_ptr moves only on an accept, so a
   // withdrawn request leaves the rotation untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_sum   <= '0;
         res_cout  <= 1'b0;
         res_of    <= 1'b0;
         res_id    <= '0;
         rr_ptr    <= '0;
      end else if (accept) begin
         res_valid <= 1'b1;
         res_sum   <= sum_full[W-1:0];
         res_cout  <= sum_full[W];
         res_of    <= of_calc;
         res_id    <= gnt_idx;
         rr_ptr    <= ptr_next;
      end else if (res_ready) begin
         // Drained with nothing new: data registers keep their last values.
         res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adder_rr_arbiter
//
// Drives adder_rr_arbiter (W=32, NREQ=4) with directed scenarios followed by
// randomized traffic. Expected values come from a reference model: a
// pointer integer for round-robin order, plain integer arithmetic for the
// adder, and an expected-result queue for the output stage.
// ---------------------------------------------------------------------------
module tb_adder_rr_arbiter;

   localparam int W    = 32;
   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int RW   = IDW + 2 + W;   // {id, of, cout, sum}

   // ---------------------------------------------------------------- clock/reset
   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a = '0;
   logic [NREQ*W-1:0] req_b = '0;
   logic [NREQ-1:0]   req_cin = '0;
   logic              res_valid;
   logic              res_ready = 1'b0;
   logic [W-1:0]      res_sum;
   logic              res_cout;
   logic              res_of;
   logic [IDW-1:0]    res_id;

   always #5 clk = ~clk;

   adder_rr_arbiter #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_cout  (res_cout),
      .res_of    (res_of),
      .res_id    (res_id)
   );

   // ---------------------------------------------------------------- stimulus state
   logic [W-1:0] op_a [NREQ];
   logic [W-1:0] op_b [NREQ];
   logic         op_c [NREQ];
   logic         op_v [NREQ];
   logic         rdy;

   // ---------------------------------------------------------------- scoreboard
   logic [RW-1:0] exp_q[$];
   int            m_ptr;
   int            last_grant;
   int            n_checks = 0;
   int            n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference adder: unsigned sum for sum/carry, signed sum for overflow.
   function automatic logic [RW-1:0] ref_add(input int id, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic c);
      longint unsigned s;
      longint          ss;
      longint          lim;
      logic            of;
      s   = a;
      s   = s + b + c;
      ss  = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
      lim = longint'(1) <<< (W-1);
      of  = (ss >= lim) || (ss < -lim);
      return {IDW'(id), of, s[W], s[W-1:0]};
   endfunction

   // ---------------------------------------------------------------- driver tasks
   task automatic apply();
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*W +: W] = op_a[i];
         req_b[i*W +: W] = op_b[i];
         req_cin[i]      = op_c[i];
         req_valid[i]    = op_v[i];
      end
      res_ready = rdy;
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < NREQ; i++) begin
         op_a[i] = '0;
         op_b[i] = '0;
         op_c[i] = 1'b0;
         op_v[i] = 1'b0;
      end
   endtask

   // One clock cycle, entered and left on a falling edge. Checks the
   // combinational grant and the registered outputs against the model,
   // then advances the model across the rising edge.
   task automatic cyc();
      int              g;
      logic            load;
      logic [NREQ-1:0] exp_rdy;
      logic [RW-1:0]   head;
      apply();
      #1;
      g       = -1;
      exp_rdy = '0;
      load    = (exp_q.size() == 0) || rdy;
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (m_ptr + k) % NREQ;
         if (g < 0 && op_v[idx]) g = idx;
      end
      if (g >= 0 && load) exp_rdy[g] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      check("res_valid", 64'(res_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         head = exp_q[0];
         check("res_sum",  64'(res_sum),  64'(head[W-1:0]));
         check("res_cout", 64'(res_cout), 64'(head[W]));
         check("res_of",   64'(res_of),   64'(head[W+1]));
         check("res_id",   64'(res_id),   64'(head[RW-1 -: IDW]));
      end
      if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
      last_grant = -1;
      if (g >= 0 && load) begin
         exp_q.push_back(ref_add(g, op_a[g], op_b[g], op_c[g]));
         m_ptr      = (g + 1) % NREQ;
         last_grant = g;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   // Reset pulse entered on a falling edge; checks async clear before any edge.
   task automatic do_reset();
      rst_n = 1'b0;
      apply();
      #1;
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_res_sum",   64'(res_sum),   64'd0);
      check("rst_res_id",    64'(res_id),    64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      m_ptr = 0;
   endtask

   // Single request on requester r, then drain; returns with the result
   // visible on the outputs.
   task automatic single(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      clear_reqs();
      op_v[r] = 1'b1;
      op_a[r] = a;
      op_b[r] = b;
      op_c[r] = c;
      rdy     = 1'b1;
      cyc();
      op_v[r] = 1'b0;
   endtask

   // ---------------------------------------------------------------- main sequence
   initial begin
      m_ptr      = 0;
      last_grant = -1;
      rdy        = 1'b1;
      clear_reqs();
      op_v[1] = 1'b1;   // a request during reset must not be granted
      @(negedge clk);
      do_reset();
      clear_reqs();

      // Idle after reset.
      for (int i = 0; i < 10; i++) begin
         cyc();
         check("idle_sum", 64'(res_sum), 64'd0);
      end

      // Single request from requester 2.
      single(2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
      check("single_valid", 64'(res_valid), 64'd1);
      check("single_sum",   64'(res_sum),   64'hFFFF_FFFE);
      check("single_cout",  64'(res_cout),  64'd0);
      check("single_of",    64'(res_of),    64'd1);
      check("single_id",    64'(res_id),    64'd2);
      cyc();

      // Round robin from a fresh pointer.
      @(negedge clk);
      do_reset();
      clear_reqs();
      for (int i = 0; i < NREQ; i++) begin
         op_v[i] = 1'b1;
         op_a[i] = W'(i);
         op_b[i] = 32'h10;
         op_c[i] = 1'b1;
      end
      rdy = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cyc();
         check("rr_sum", 64'(res_sum), 64'(32'h11 + (k % NREQ)));
         check("rr_id",  64'(res_id),  64'(k % NREQ));
      end
      clear_reqs();
      cyc();
      cyc();

      // Backpressure: pending result, stall three cycles with req 1 waiting.
      single(0, 32'h1234, 32'h1, 1'b0);
      op_v[1] = 1'b1;
      op_a[1] = 32'hAAAA_0000;
      op_b[1] = 32'h0000_5555;
      rdy     = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("bp_hold_sum", 64'(res_sum), 64'h1235);
      end
      rdy = 1'b1;
      cyc();
      op_v[1] = 1'b0;
      check("bp_after_sum", 64'(res_sum), 64'hAAAA_5555);
      check("bp_after_id",  64'(res_id),  64'd1);
      cyc();

      // Arithmetic corners.
      single(0, 32'h8FFF_FFFF, 32'h8FFF_FFFF, 1'b0);
      check("c1_sum", 64'(res_sum), 64'h1FFF_FFFE);
      check("c1_cout", 64'(res_cout), 64'd1);
      check("c1_of",  64'(res_of),  64'd1);
      single(1, 32'h7AA, 32'hFFFF_FFFF, 1'b0);
      check("c2_sum", 64'(res_sum), 64'h7A9);
      check("c2_cout", 64'(res_cout), 64'd1);
      check("c2_of",  64'(res_of),  64'd0);
      single(2, 32'h0, 32'hFFFF_FFFF, 1'b0);
      check("c3_sum", 64'(res_sum), 64'hFFFF_FFFF);
      check("c3_cout", 64'(res_cout), 64'd0);
      check("c3_of",  64'(res_of),  64'd0);
      single(3, 32'hFFFF_FFFF, 32'h0, 1'b1);
      check("c4_sum", 64'(res_sum), 64'h0);
      check("c4_cout", 64'(res_cout), 64'd1);
      cyc();

      // Withdrawal: req 3 raised during a stall, dropped before ready.
      single(1, 32'h5, 32'h6, 1'b0);   // pointer now 2
      rdy     = 1'b0;
      op_v[3] = 1'b1;
      op_a[3] = 32'hDEAD;
      op_b[3] = 32'hBEEF;
      cyc();
      cyc();
      op_v[3] = 1'b0;
      cyc();
      rdy = 1'b1;
      cyc();
      cyc();
      check("wd_no_result", 64'(res_valid), 64'd0);
      // Pointer still at 2: with req 0 and 3 valid, 3 must win first.
      op_v[0] = 1'b1;
      op_v[3] = 1'b1;
      cyc();
      check("wd_next_id", 64'(res_id), 64'd3);
      clear_reqs();
      cyc();

      // Reset in the middle of a stall.
      single(2, 32'h100, 32'h200, 1'b0);
      rdy     = 1'b0;
      op_v[0] = 1'b1;
      cyc();
      do_reset();
      clear_reqs();
      rdy = 1'b1;
      cyc();

      // Randomized traffic with operand holding while waiting.
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (op_v[i] && last_grant != i) begin
               if ($urandom_range(0, 9) == 0) op_v[i] = 1'b0;
            end else if ($urandom_range(0, 1) == 1) begin
               op_v[i] = 1'b1;
               case ($urandom_range(0, 3))
                  0: op_a[i] = 32'h7FFF_FFFF;
                  1: op_a[i] = 32'h8000_0000;
                  default: op_a[i] = $urandom;
               endcase
               op_b[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
               op_c[i] = 1'($urandom_range(0, 1));
            end else begin
               op_v[i] = 1'b0;
            end
         end
         rdy = ($urandom_range(0, 9) < 7);
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
